prc_seg_fetch: RTL

- Packet Read Controller front end, directly downstream of the Packet Fetch Scheduler (PFS).
- Accepts scheduled packet-fetch descriptors (head segment pointer, byte length, egress port) from PFS and buffers them in a small FIFO.
- Expands each descriptor into per-segment read requests toward packet memory, tagging SOP/EOP and valid byte count.
- Throttles issue with an outstanding-read credit counter that is replenished by read completions.

---
 rtl/prc_seg_fetch.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/prc_seg_fetch.sv
// Packet Read Controller front end: buffers packet-fetch descriptors from the
// scheduler and expands each one into per-segment read requests toward packet
// memory. Issue is throttled by an outstanding-read credit counter that is
// replenished by read completions.
module prc_seg_fetch #(
    parameter int SEG_PTR_W     = 16,
    parameter int LEN_W         = 14,
    parameter int PORT_W        = 5,
    parameter int SEG_BYTES_LG2 = 8,
    parameter int DESC_DEPTH    = 4,
    parameter int MAX_OUT       = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pfs_req_valid,
    output logic                     o_pfs_req_ready,
    input  logic [SEG_PTR_W-1:0]     i_pfs_req_ptr,
    input  logic [LEN_W-1:0]         i_pfs_req_len,
    input  logic [PORT_W-1:0]        i_pfs_req_port,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [SEG_PTR_W-1:0]     o_rd_ptr,
    output logic [PORT_W-1:0]        o_rd_port,
    output logic                     o_rd_sop,
    output logic                     o_rd_eop,
    output logic [SEG_BYTES_LG2:0]   o_rd_bytes,
    input  logic                     i_rd_cpl,
    output logic                     o_pkt_done,
    output logic                     o_err_zero_len,
    output logic                     o_err_cpl
);

    localparam int AW      = $clog2(DESC_DEPTH);
    localparam int DESC_W  = SEG_PTR_W + LEN_W + PORT_W;
    localparam int SEG_W   = LEN_W - SEG_BYTES_LG2 + 1;
    localparam int BYTES_W = SEG_BYTES_LG2 + 1;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [BYTES_W-1:0] FULL_SEG = {1'b1, {SEG_BYTES_LG2{1'b0}}};

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    // Descriptor FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [DESC_W-1:0]    r_mem [DESC_DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;

    // Current packet context
    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEG_PTR_W-1:0] r_cur_ptr;
    logic [PORT_W-1:0]    r_cur_port;
    logic [SEG_W-1:0]     r_rem_seg;
    logic [BYTES_W-1:0]   r_last_bytes;
    logic                 r_first;
    logic [CNT_W-1:0]     r_out_cnt;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_load;
    logic                 w_advance;
    logic                 w_fire;
    logic                 w_issue;

    logic [DESC_W-1:0]    w_head;
    logic [SEG_PTR_W-1:0] w_head_ptr;
    logic [LEN_W-1:0]     w_head_len;
    logic [PORT_W-1:0]    w_head_port;
    logic [SEG_BYTES_LG2-1:0] w_head_lo;
    logic [SEG_W-1:0]     w_head_segs;
    logic [BYTES_W-1:0]   w_head_last;
    logic                 w_head_zero;

    // Ready comes only from registered pointer state, so a same-cycle pop never
    // re-opens a full FIFO.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_pfs_req_ready = !w_full;
    assign w_push  = i_pfs_req_valid && !w_full;

    // Decode the head descriptor into segment count and bytes in the last segment
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_ptr  = w_head[DESC_W-1 -: SEG_PTR_W];
    assign w_head_len  = w_head[PORT_W +: LEN_W];
    assign w_head_port = w_head[PORT_W-1:0];
    assign w_head_lo   = w_head_len[SEG_BYTES_LG2-1:0];
    assign w_head_segs = SEG_W'(w_head_len[LEN_W-1:SEG_BYTES_LG2]) + SEG_W'(w_head_lo != '0);
    assign w_head_last = (w_head_lo == '0) ? FULL_SEG : {1'b0, w_head_lo};
    assign w_head_zero = (w_head_len == '0);

    // A completion in the same cycle frees a credit. Without a fire the counter
    // cannot grow, so a raised rd_valid stays up until it is accepted.
    assign w_issue    = (r_state == ISSUE);
    assign o_rd_valid = w_issue && ((r_out_cnt < CNT_W'(MAX_OUT)) || i_rd_cpl);
    assign w_fire     = o_rd_valid && i_rd_ready;
    assign o_rd_ptr   = r_cur_ptr;
    assign o_rd_port  = r_cur_port;
    assign o_rd_sop   = w_issue && r_first;
    assign o_rd_eop   = w_issue && (r_rem_seg == SEG_W'(1));
    assign o_rd_bytes = !w_issue ? '0 : (o_rd_eop ? r_last_bytes : FULL_SEG);
    assign o_err_cpl  = i_rd_cpl && !w_fire && (r_out_cnt == '0);

    // Storage is write-only on push; it needs no reset because pointers gate reads
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_pfs_req_ptr, i_pfs_req_len, i_pfs_req_port};
        end
    end

    // FIFO pointer update; reset discards every queued descriptor
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: pop in IDLE, or on the last fire for zero-bubble back-to-back
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_load         = 1'b0;
        w_advance      = 1'b0;
        o_pkt_done     = 1'b0;
        o_err_zero_len = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_zero) begin
                        o_err_zero_len = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (w_fire) begin
                    if (o_rd_eop) begin
                        o_pkt_done = 1'b1;
                        if (!w_empty) begin
                            w_pop = 1'b1;
                            if (w_head_zero) begin
                                o_err_zero_len = 1'b1;
                                w_state_nxt    = IDLE;
                            end else begin
                                w_load = 1'b1;
                            end
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Packet context: load a fresh descriptor or step to the next segment
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur_ptr    <= '0;
            r_cur_port   <= '0;
            r_rem_seg    <= '0;
            r_last_bytes <= '0;
            r_first      <= 1'b0;
        end else if (w_load) begin
            r_cur_ptr    <= w_head_ptr;
            r_cur_port   <= w_head_port;
            r_rem_seg    <= w_head_segs;
            r_last_bytes <= w_head_last;
            r_first      <= 1'b1;
        end else if (w_advance) begin
            r_cur_ptr    <= r_cur_ptr + SEG_PTR_W'(1);
            r_rem_seg    <= r_rem_seg - SEG_W'(1);
            r_first      <= 1'b0;
        end
    end

    // Outstanding-read credits: fire adds, completion returns, both cancel out
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_cnt <= '0;
        end else if (w_fire && !i_rd_cpl) begin
            r_out_cnt <= r_out_cnt + CNT_W'(1);
        end else if (!w_fire && i_rd_cpl && (r_out_cnt != '0)) begin
            r_out_cnt <= r_out_cnt - CNT_W'(1);
        end
    end

endmodule
